// File: rtl/aes_inv_sbox_seq.sv
// aes_inv_sbox_seq: sequential AES inverse S-box for one byte.
// It computes InvSbox(s) = InvAffine(s)^254 in GF(2^8) (poly 0x11B).
// A single shared GF multiplier does square-and-multiply over 13 steps.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data stable until that edge. ready
// never depends on valid in the same cycle. in_ready=1 only in IDLE.
// out_valid=1 only in DONE, and out_data is stable for the whole of DONE.
module aes_inv_sbox_seq #(
  parameter bit LED_HOLD = 1'b1,
  parameter int COUNT_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               KEY,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [COUNT_W-1:0] done_count,
  output logic [9:0]         LEDR,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  acc;
  logic [7:0]  base;
  logic [3:0]  step;
  logic [7:0]  mul_b;
  logic [7:0]  product;
  logic [7:0]  inv_aff;

  // GF(2^8) multiply: shift-and-add, reducing by 0x1B on every carry out.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map and the single shared multiplier. Even steps square
  // the accumulator and odd steps multiply it by the base.
  always_comb begin
    inv_aff = {in_data[6:0], in_data[7]}
            ^ {in_data[4:0], in_data[7:5]}
            ^ {in_data[1:0], in_data[7:2]}
            ^ 8'h05;
    mul_b   = step[0] ? base : acc;
    product = gf_mul(acc, mul_b);
  end

  // Control FSM and datapath registers. Step 12 squares base^127 into out_data.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      state      <= IDLE;
      acc        <= 8'h00;
      base       <= 8'h00;
      step       <= 4'd0;
      out_data   <= 8'h00;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base  <= inv_aff;
            acc   <= inv_aff;
            step  <= 4'd0;
            state <= CALC;
          end
        end
        CALC: begin
          if (step == 4'd12) begin
            out_data <= product;
            state    <= DONE;
          end else begin
            acc  <= product;
            step <= step + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            done_count <= done_count + COUNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are decoded from registered state and the result register only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    fsm_state = state;
    LEDR[9]   = (state == CALC);
    LEDR[8]   = (state == DONE);
    LEDR[7:0] = (LED_HOLD || state == DONE) ? out_data : 8'h00;
  end

endmodule
